mdio_responder: RTL and testbench

- PHY-side MDIO management slave (Clause 22): the far end of the team's MDIO master.
- Decodes serial management frames on mdio_in and hosts a 32 x 16 register file.
- Answers read frames by driving mdio_out/mdio_oe toward the pad IOBUF.
- Exposes a host-side port so local PHY logic can update status registers and observe management writes.
- Used as the bench model for the master and as the management target in loopback builds.

---
 rtl/mdio_responder.sv | 160 ++++++++++++++++
 tb/tb_mdio_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO management slave with a 32 x 16 register file and host-side access port.
module mdio_responder #(
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2,
  parameter bit          BCAST_EN     = 1'b1
) (
  input  logic        clk_8_3mhz,
  input  logic        reset_n,
  input  logic [4:0]  phy_addr,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        host_wr_en,
  input  logic [4:0]  host_wr_addr,
  input  logic [15:0] host_wr_data,
  input  logic [4:0]  host_rd_addr,
  output logic [15:0] host_rd_data,
  output logic        mgmt_wr_strobe,
  output logic [4:0]  mgmt_wr_addr,
  output logic [15:0] mgmt_wr_data,
  output logic        mgmt_rd_strobe,
  output logic        frame_err
);
  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  typedef enum logic [2:0] {IDLE, START, OP, PHYAD, REGAD, TA, DATA, IGNORE} state_t;
  state_t        state;
  logic [PW-1:0] pre;
  logic [4:0]    cnt;
  logic [4:0]    regad;
  logic [15:0]   sh;
  logic          op_hi;
  logic          rd;
  logic          drive;
  logic [15:0]   regs [32];
  logic [4:0]    pa_next;
  logic [4:0]    ra_next;
  logic [15:0]   wd_next;

  function automatic logic is_id(input logic [4:0] a);
    return a == 5'd2 || a == 5'd3;
  endfunction

  function automatic logic [15:0] rf(input logic [4:0] a);
    return a == 5'd2 ? PHY_ID1 : a == 5'd3 ? PHY_ID2 : regs[a];
  endfunction

  assign host_rd_data = rf(host_rd_addr);
  assign pa_next = {sh[3:0], mdio_in};
  assign ra_next = {regad[3:0], mdio_in};
  assign wd_next = {sh[14:0], mdio_in};
  assign drive   = rd && (state == DATA || (state == TA && cnt[0]));

  always_ff @(posedge clk_8_3mhz) begin
    if (!reset_n) begin
      state          <= IDLE;
      pre            <= '0;
      cnt            <= '0;
      regad          <= '0;
      sh             <= '0;
      op_hi          <= 1'b0;
      rd             <= 1'b0;
      mgmt_wr_strobe <= 1'b0;
      mgmt_wr_addr   <= '0;
      mgmt_wr_data   <= '0;
      mgmt_rd_strobe <= 1'b0;
      frame_err      <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      mgmt_wr_strobe <= 1'b0;
      mgmt_rd_strobe <= 1'b0;
      frame_err      <= 1'b0;
      if (host_wr_en && !is_id(host_wr_addr)) regs[host_wr_addr] <= host_wr_data;
      // management commit below is assigned later, so it overrides a same-address host write
      case (state)
        IDLE: begin
          if (mdio_in) pre <= (pre == PW'(PREAMBLE_MIN)) ? pre : pre + 1'b1;
          else begin
            if (pre >= PW'(PREAMBLE_MIN)) state <= START;
            pre <= '0;
          end
        end
        START: begin
          state     <= mdio_in ? OP : IDLE;
          frame_err <= !mdio_in;
          cnt       <= '0;
        end
        OP: begin
          if (!cnt[0]) begin
            op_hi <= mdio_in;
            cnt   <= 5'd1;
          end else if (op_hi != mdio_in) begin
            rd    <= op_hi;
            state <= PHYAD;
            cnt   <= '0;
          end else begin
            frame_err <= 1'b1;
            state     <= IGNORE;
            cnt       <= 5'd27;
          end
        end
        PHYAD: begin
          sh <= wd_next;
          if (cnt == 5'd4) begin
            if (pa_next == phy_addr || (BCAST_EN && pa_next == 5'd0 && !rd)) begin
              state <= REGAD;
              cnt   <= '0;
            end else begin
              state <= IGNORE;
              cnt   <= 5'd22;
            end
          end else cnt <= cnt + 1'b1;
        end
        REGAD: begin
          regad <= ra_next;
          if (cnt == 5'd4) begin
            state <= TA;
            cnt   <= '0;
            if (rd) begin
              sh             <= rf(ra_next);
              mgmt_rd_strobe <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        TA: begin
          state <= cnt[0] ? DATA : TA;
          cnt   <= cnt[0] ? 5'd0 : 5'd1;
        end
        DATA: begin
          if (!rd) sh <= wd_next;
          if (cnt == 5'd15) begin
            state <= IDLE;
            cnt   <= '0;
            if (!rd && !is_id(regad)) begin
              regs[regad]    <= wd_next;
              mgmt_wr_strobe <= 1'b1;
              mgmt_wr_addr   <= regad;
              mgmt_wr_data   <= wd_next;
            end
          end else cnt <= cnt + 1'b1;
        end
        IGNORE: begin
          state <= cnt == 5'd0 ? IDLE : IGNORE;
          cnt   <= cnt == 5'd0 ? 5'd0 : cnt - 1'b1;
        end
      endcase
    end
  end

  // pad drive changes on the falling edge, half a period ahead of the master's sampling edge
  always_ff @(negedge clk_8_3mhz) begin
    if (!reset_n) begin
      mdio_oe  <= 1'b0;
      mdio_out <= 1'b1;
    end else begin
      mdio_oe  <= drive;
      mdio_out <= drive ? (state == DATA && sh[~cnt[3:0]]) : 1'b1;
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: randomized frame-level bench for mdio_responder against a register-file reference model.
module tb_mdio_responder;
  logic        clk_8_3mhz = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  phy_addr = 5'h01;
  logic        m_drv = 1'b1;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic        host_wr_en = 1'b0;
  logic [4:0]  host_wr_addr = '0;
  logic [15:0] host_wr_data = '0;
  logic [4:0]  host_rd_addr = '0;
  logic [15:0] host_rd_data;
  logic        mgmt_wr_strobe;
  logic [4:0]  mgmt_wr_addr;
  logic [15:0] mgmt_wr_data;
  logic        mgmt_rd_strobe;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_err = 0;
  logic [15:0]  mem [32];
  logic [127:0] obs_oe, obs_out, exp_oe, exp_out;

  // open-drain pad with pull-up: the master releases by driving 1, the slave overrides when enabled
  assign mdio_in = mdio_oe ? mdio_out : m_drv;

  mdio_responder dut (
    .clk_8_3mhz(clk_8_3mhz), .reset_n(reset_n), .phy_addr(phy_addr),
    .mdio_in(mdio_in), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .mgmt_wr_strobe(mgmt_wr_strobe), .mgmt_wr_addr(mgmt_wr_addr), .mgmt_wr_data(mgmt_wr_data),
    .mgmt_rd_strobe(mgmt_rd_strobe), .frame_err(frame_err)
  );

  always #5 clk_8_3mhz = ~clk_8_3mhz;

  always @(negedge clk_8_3mhz) begin
    if (mgmt_wr_strobe) n_wr++;
    if (mgmt_rd_strobe) n_rd++;
    if (frame_err) n_err++;
  end

  function automatic logic [15:0] model_rd(input logic [4:0] a);
    return a == 5'd2 ? 16'h0141 : a == 5'd3 ? 16'h0CC2 : mem[a];
  endfunction

  task automatic model_clear;
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  // expected pad waveform per bit period: TA2 drives 0, then D15..D0, released otherwise
  task automatic build_exp(input bit drv, input int p, input logic [15:0] d);
    exp_oe = '0;
    exp_out = '1;
    if (drv) begin
      exp_oe[p+15] = 1'b1;
      exp_out[p+15] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        exp_oe[p+16+i] = 1'b1;
        exp_out[p+16+i] = d[15-i];
      end
    end
  endtask

  task automatic send_bit(input logic b, input int idx);
    @(negedge clk_8_3mhz);
    m_drv = b;
    #1;
    obs_oe[idx] = mdio_oe;
    obs_out[idx] = mdio_out;
  endtask

  task automatic run_frame(input logic [1:0] st, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] d, input int p, input bit hw,
                           input logic [4:0] hwa, input logic [15:0] hwd, input int rst_at);
    logic [31:0] fr;
    fr = {st, op, pa, ra, (op == 2'b10) ? 2'b11 : 2'b10, (op == 2'b10) ? 16'hFFFF : d};
    obs_oe = '0;
    obs_out = '1;
    for (int i = 0; i < p; i++) send_bit(1'b1, i);
    for (int i = 0; i < 32; i++) begin
      send_bit(fr[31-i], p + i);
      if (p + i == rst_at) begin
        #2 reset_n = 1'b0;
      end
      if (p + i == rst_at + 1) reset_n = 1'b1;
      if (i == 31 && hw) begin
        host_wr_en = 1'b1;
        host_wr_addr = hwa;
        host_wr_data = hwd;
      end
    end
    send_bit(1'b1, p + 32);
    host_wr_en = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_8_3mhz);
    host_rd_addr = 5'd4;
    #1;
    checks++; if (mdio_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", mdio_oe); end
    checks++; if (mdio_out !== 1'b1) begin errors++; $display("FAIL reset_out got %b exp 1", mdio_out); end
    checks++; if ({mgmt_wr_strobe, mgmt_rd_strobe, frame_err} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {mgmt_wr_strobe, mgmt_rd_strobe, frame_err}); end
    checks++; if ({mgmt_wr_addr, mgmt_wr_data} !== 21'h0) begin errors++; $display("FAIL reset_mgmt got %h exp 0", {mgmt_wr_addr, mgmt_wr_data}); end
    checks++; if (host_rd_data !== 16'h0) begin errors++; $display("FAIL reset_reg4 got %h exp 0", host_rd_data); end
    reset_n = 1'b1;
  endtask

  task automatic test_read_id;
    for (int r = 2; r < 4; r++) begin
      int r0;
      r0 = n_rd;
      run_frame(2'b01, 2'b10, 5'h01, 5'(r), 16'h0, 32, 1'b0, '0, '0, -1);
      build_exp(1'b1, 32, model_rd(5'(r)));
      checks++; if (obs_oe !== exp_oe) begin errors++; $display("FAIL read_id_oe reg %0d got %h exp %h", r, obs_oe, exp_oe); end
      checks++; if (obs_out !== exp_out) begin errors++; $display("FAIL read_id_out reg %0d got %h exp %h", r, obs_out, exp_out); end
      checks++; if ($countones(obs_oe) != 17) begin errors++; $display("FAIL read_id_oe_len got %0d exp 17", $countones(obs_oe)); end
      checks++; if (n_rd - r0 != 1) begin errors++; $display("FAIL read_id_strobe got %0d exp 1", n_rd - r0); end
    end
  endtask

  task automatic test_write_read;
    int w0;
    w0 = n_wr;
    run_frame(2'b01, 2'b01, 5'h01, 5'h04, 16'hA5C3, 32, 1'b0, '0, '0, -1);
    mem[4] = 16'hA5C3;
    host_rd_addr = 5'd4;
    #1;
    checks++; if (n_wr - w0 != 1) begin errors++; $display("FAIL wr_strobe got %0d exp 1", n_wr - w0); end
    checks++; if (mgmt_wr_addr !== 5'd4) begin errors++; $display("FAIL wr_addr got %h exp 4", mgmt_wr_addr); end
    checks++; if (mgmt_wr_data !== 16'hA5C3) begin errors++; $display("FAIL wr_data got %h exp a5c3", mgmt_wr_data); end
    checks++; if (host_rd_data !== 16'hA5C3) begin errors++; $display("FAIL wr_host_rd got %h exp a5c3", host_rd_data); end
    checks++; if (obs_oe !== '0) begin errors++; $display("FAIL wr_oe got %h exp 0", obs_oe); end
    run_frame(2'b01, 2'b10, 5'h01, 5'h04, 16'h0, 32, 1'b0, '0, '0, -1);
    build_exp(1'b1, 32, 16'hA5C3);
    checks++; if ({obs_oe, obs_out} !== {exp_oe, exp_out}) begin errors++; $display("FAIL rd_back got %h/%h exp %h/%h", obs_oe, obs_out, exp_oe, exp_out); end
  endtask

  task automatic test_addr_filter;
    int w0, r0;
    logic [15:0] d;
    d = 16'($urandom);
    w0 = n_wr;
    run_frame(2'b01, 2'b01, 5'h07, 5'h05, d, 32, 1'b0, '0, '0, -1);
    host_rd_addr = 5'd5;
    #1;
    checks++; if (n_wr != w0) begin errors++; $display("FAIL mismatch_strobe got %0d exp 0", n_wr - w0); end
    checks++; if (obs_oe !== '0) begin errors++; $display("FAIL mismatch_oe got %h exp 0", obs_oe); end
    checks++; if (host_rd_data !== mem[5]) begin errors++; $display("FAIL mismatch_reg got %h exp %h", host_rd_data, mem[5]); end
    run_frame(2'b01, 2'b01, 5'h00, 5'h05, d, 32, 1'b0, '0, '0, -1);
    mem[5] = d;
    #1;
    checks++; if (n_wr - w0 != 1) begin errors++; $display("FAIL bcast_strobe got %0d exp 1", n_wr - w0); end
    checks++; if (host_rd_data !== d) begin errors++; $display("FAIL bcast_reg got %h exp %h", host_rd_data, d); end
    r0 = n_rd;
    run_frame(2'b01, 2'b10, 5'h00, 5'h05, 16'h0, 32, 1'b0, '0, '0, -1);
    checks++; if (obs_oe !== '0 || n_rd != r0) begin errors++; $display("FAIL bcast_read got oe %h strobes %0d exp 0", obs_oe, n_rd - r0); end
  endtask

  task automatic test_frame_err;
    int e0, r0, w0;
    e0 = n_err; r0 = n_rd; w0 = n_wr;
    send_bit(1'b0, 0);
    run_frame(2'b01, 2'b10, 5'h01, 5'h02, 16'h0, 31, 1'b0, '0, '0, -1);
    checks++; if (obs_oe !== '0 || n_rd != r0 || n_err != e0) begin errors++; $display("FAIL short_pre got oe %h rd %0d err %0d exp 0", obs_oe, n_rd - r0, n_err - e0); end
    run_frame(2'b00, 2'b01, 5'h01, 5'h06, 16'h1234, 32, 1'b0, '0, '0, -1);
    checks++; if (n_err - e0 != 1 || n_wr != w0) begin errors++; $display("FAIL bad_st got err %0d wr %0d exp 1/0", n_err - e0, n_wr - w0); end
    run_frame(2'b01, 2'b00, 5'h01, 5'h06, 16'h5678, 32, 1'b0, '0, '0, -1);
    checks++; if (n_err - e0 != 2 || n_wr != w0) begin errors++; $display("FAIL op00 got err %0d wr %0d exp 2/0", n_err - e0, n_wr - w0); end
    run_frame(2'b01, 2'b11, 5'h01, 5'h04, 16'hFFFF, 32, 1'b0, '0, '0, -1);
    checks++; if (n_err - e0 != 3 || n_wr != w0 || obs_oe !== '0) begin errors++; $display("FAIL op11 got err %0d wr %0d oe %h exp 3/0/0", n_err - e0, n_wr - w0, obs_oe); end
    // trailing idle bit plus 31 ones forms exactly the minimum preamble once the ignored bits are done
    run_frame(2'b01, 2'b10, 5'h01, 5'h04, 16'h0, 31, 1'b0, '0, '0, -1);
    build_exp(1'b1, 31, model_rd(5'h04));
    checks++; if ({obs_oe, obs_out} !== {exp_oe, exp_out}) begin errors++; $display("FAIL after_ignore got %h/%h exp %h/%h", obs_oe, obs_out, exp_oe, exp_out); end
  endtask

  task automatic test_collision;
    run_frame(2'b01, 2'b01, 5'h01, 5'h04, 16'h2222, 32, 1'b1, 5'h04, 16'h1111, -1);
    mem[4] = 16'h2222;
    host_rd_addr = 5'd4;
    #1;
    checks++; if (host_rd_data !== 16'h2222) begin errors++; $display("FAIL coll_same got %h exp 2222", host_rd_data); end
    run_frame(2'b01, 2'b01, 5'h01, 5'h06, 16'h3333, 32, 1'b1, 5'h07, 16'h4444, -1);
    mem[6] = 16'h3333; mem[7] = 16'h4444;
    host_rd_addr = 5'd6;
    #1;
    checks++; if (host_rd_data !== 16'h3333) begin errors++; $display("FAIL coll_mgmt got %h exp 3333", host_rd_data); end
    host_rd_addr = 5'd7;
    #1;
    checks++; if (host_rd_data !== 16'h4444) begin errors++; $display("FAIL coll_host got %h exp 4444", host_rd_data); end
    @(negedge clk_8_3mhz);
    host_wr_en = 1'b1; host_wr_addr = 5'd3; host_wr_data = 16'hFFFF;
    @(negedge clk_8_3mhz);
    host_wr_en = 1'b0;
    host_rd_addr = 5'd3;
    #1;
    checks++; if (host_rd_data !== 16'h0CC2) begin errors++; $display("FAIL host_id got %h exp 0cc2", host_rd_data); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      logic [4:0] ra, pa;
      logic [15:0] d;
      bit hit;
      int w0;
      ra = 5'($urandom_range(0, 31));
      d = 16'($urandom);
      pa = (it % 3 == 0) ? 5'd0 : (it % 3 == 1) ? 5'd1 : 5'($urandom_range(2, 31));
      hit = pa <= 5'd1 && ra != 5'd2 && ra != 5'd3;
      w0 = n_wr;
      run_frame(2'b01, 2'b01, pa, ra, d, 32, 1'b0, '0, '0, -1);
      if (hit) mem[ra] = d;
      host_rd_addr = ra;
      #1;
      checks++; if (n_wr - w0 != int'(hit)) begin errors++; $display("FAIL rand_wr_strobe it %0d got %0d exp %0d", it, n_wr - w0, int'(hit)); end
      checks++; if (host_rd_data !== model_rd(ra)) begin errors++; $display("FAIL rand_reg it %0d got %h exp %h", it, host_rd_data, model_rd(ra)); end
      ra = 5'($urandom_range(0, 31));
      run_frame(2'b01, 2'b10, 5'h01, ra, 16'h0, 32, 1'b0, '0, '0, -1);
      build_exp(1'b1, 32, model_rd(ra));
      checks++; if ({obs_oe, obs_out} !== {exp_oe, exp_out}) begin errors++; $display("FAIL rand_read it %0d reg %0d got %h/%h exp %h/%h", it, ra, obs_oe, obs_out, exp_oe, exp_out); end
    end
  endtask

  task automatic test_reset_midframe;
    run_frame(2'b01, 2'b10, 5'h01, 5'h04, 16'h0, 32, 1'b0, '0, '0, 32 + 24);
    model_clear();
    checks++; if (obs_oe[56] !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", obs_oe[56]); end
    checks++; if ({obs_oe[57], obs_out[57]} !== 2'b01) begin errors++; $display("FAIL midrst_release got %b exp 01", {obs_oe[57], obs_out[57]}); end
    host_rd_addr = 5'd4;
    #1;
    checks++; if (host_rd_data !== 16'h0) begin errors++; $display("FAIL midrst_reg got %h exp 0", host_rd_data); end
    run_frame(2'b01, 2'b10, 5'h01, 5'h02, 16'h0, 32, 1'b0, '0, '0, -1);
    build_exp(1'b1, 32, 16'h0141);
    checks++; if ({obs_oe, obs_out} !== {exp_oe, exp_out}) begin errors++; $display("FAIL midrst_next got %h/%h exp %h/%h", obs_oe, obs_out, exp_oe, exp_out); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write_read();
    test_addr_filter();
    test_frame_err();
    test_collision();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
